// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer engine.
package spi_pkg;

    localparam int SPI_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        CPHA_DELAY,
        P0,
        P1
    } spi_state_e;

endpackage

// File: rtl/spi_xfer_engine_if.sv
// Host command/status and serial-line bundle for spi_xfer_engine.
// The host side uses the master modport and the engine uses the slave modport.
interface spi_xfer_engine_if #(
    parameter int DVSR_BITS = 16
);
    import spi_pkg::*;

    logic [DVSR_BITS-1:0]     dvsr;
    logic                     cpol;
    logic                     cpha;
    logic                     start;
    logic [SPI_DATA_BITS-1:0] mosi_data;
    logic                     miso;
    logic [SPI_DATA_BITS-1:0] miso_data;
    logic                     ready;
    logic                     done_tick;
    logic                     spi_clk;
    logic                     mosi;

    modport master (
        output dvsr, cpol, cpha, start, mosi_data, miso,
        input  miso_data, ready, done_tick, spi_clk, mosi
    );

    modport slave (
        input  dvsr, cpol, cpha, start, mosi_data, miso,
        output miso_data, ready, done_tick, spi_clk, mosi
    );

endinterface

// File: rtl/spi_xfer_engine.sv
// Single-byte SPI master with programmable half-period, CPOL and CPHA.
// Bit order is MSB first unless SPI_XFER_LSB_FIRST_EN is defined.
module spi_xfer_engine
    import spi_pkg::*;
#(
    parameter int DVSR_BITS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    spi_xfer_engine_if.slave bus
);

    localparam int BIT_W = $clog2(SPI_DATA_BITS);

    spi_state_e               state_q, state_d;
    logic [DVSR_BITS-1:0]     cnt_q, cnt_d;
    logic [DVSR_BITS-1:0]     dvsr_q, dvsr_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [SPI_DATA_BITS-1:0] tx_q, tx_d;
    logic [SPI_DATA_BITS-1:0] rx_q, rx_d;
    logic                     cpol_q, cpol_d;
    logic                     cpha_q, cpha_d;
    logic                     spi_clk_q, spi_clk_d;

    logic                     done;
    logic                     half_last;
    logic                     cpol_eff;
    logic                     cpha_eff;
    logic                     phase;
    logic [SPI_DATA_BITS-1:0] tx_shift;
    logic [SPI_DATA_BITS-1:0] rx_shift;

`ifdef SPI_XFER_LSB_FIRST_EN
    assign bus.mosi = tx_q[0];
    assign tx_shift = {1'b0, tx_q[SPI_DATA_BITS-1:1]};
    assign rx_shift = {bus.miso, rx_q[SPI_DATA_BITS-1:1]};
`else
    assign bus.mosi = tx_q[SPI_DATA_BITS-1];
    assign tx_shift = {tx_q[SPI_DATA_BITS-2:0], 1'b0};
    assign rx_shift = {rx_q[SPI_DATA_BITS-2:0], bus.miso};
`endif

    assign half_last = (cnt_q == dvsr_q);

    // Idle tracks the live mode pins so spi_clk settles at the new CPOL
    // before a transfer; mid-transfer only the latched copies matter.
    assign cpol_eff = (state_q == IDLE) ? bus.cpol : cpol_q;
    assign cpha_eff = (state_q == IDLE) ? bus.cpha : cpha_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvsr_q    <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            spi_clk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvsr_q    <= dvsr_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            spi_clk_q <= spi_clk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvsr_d  = dvsr_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_d    = bus.mosi_data;
                    dvsr_d  = bus.dvsr;
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = bus.cpha ? CPHA_DELAY : P0;
                end
            end
            CPHA_DELAY: begin
                if (half_last) begin
                    cnt_d   = '0;
                    state_d = P0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            P0: begin
                if (half_last) begin
                    rx_d    = rx_shift;
                    cnt_d   = '0;
                    state_d = P1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            P1: begin
                if (half_last) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(SPI_DATA_BITS - 1)) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tx_d    = tx_shift;
                        bit_d   = bit_q + 1'b1;
                        state_d = P0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // spi_clk is registered from the next state so it lines up with it.
        phase     = ((state_d == P1) && !cpha_eff) || ((state_d == P0) && cpha_eff);
        spi_clk_d = phase ^ cpol_eff;
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.done_tick = done;
    assign bus.spi_clk   = spi_clk_q;
    assign bus.miso_data = rx_q;

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine with MOSI looped back to MISO.
// Expected MOSI bit order follows SPI_XFER_LSB_FIRST_EN.
module tb_spi_xfer_engine;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   npass = 0;
    int   ncheck = 0;

    always #5 clk = ~clk;

    spi_xfer_engine_if #(.DVSR_BITS(16)) bus ();
    assign bus.miso = bus.mosi;

    spi_xfer_engine #(.DVSR_BITS(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Order in which the byte appears on mosi, first bit in position 7.
    function automatic logic [7:0] wire_seq(input logic [7:0] d);
        logic [7:0] r;
`ifdef SPI_XFER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = d[i];
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic idle_cycle(input logic pol, input logic pha);
        bus.cpol = pol;
        bus.cpha = pha;
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    // Starts a transfer at the current negedge (cycle 0) and observes cycles 1..ncyc.
    task automatic xfer(input logic [15:0] dv, input logic pol, input logic pha,
                        input logic [7:0] d, input int restart_k, input bit b2b,
                        input logic [7:0] d2, input int ncyc,
                        output int done1, output int done2, output int n_done,
                        output logic [7:0] mseq, output int n_fall, output int fall_first,
                        output int fall_last, output bit rdy_low, output logic rdy_after);
        int   h, first, idx;
        logic prev;
        h = int'(dv) + 1;
        first = 1 + (pha ? h : 0);
        done1 = -1; done2 = -1; n_done = 0; mseq = '0;
        n_fall = 0; fall_first = -1; fall_last = -1; rdy_low = 1'b1; rdy_after = 1'bx;
        prev = bus.spi_clk;
        bus.dvsr = dv; bus.cpol = pol; bus.cpha = pha; bus.mosi_data = d; bus.start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (done1 < 0 && bus.ready) rdy_low = 1'b0;
            if (done1 >= 0 && k == done1 + 1) rdy_after = bus.ready;
            if (bus.done_tick) begin
                n_done++;
                if (done1 < 0) done1 = k;
                else if (done2 < 0) done2 = k;
            end
            if (k >= first && (k - first) % (2 * h) == 0 && (k - first) / (2 * h) < 8) begin
                idx = 7 - (k - first) / (2 * h);
                mseq[idx] = bus.mosi;
            end
            if (prev === 1'b1 && bus.spi_clk === 1'b0) begin
                n_fall++;
                if (fall_first < 0) fall_first = k;
                fall_last = k;
            end
            prev = bus.spi_clk;
            bus.start = 1'b0; bus.dvsr = dv; bus.cpol = pol; bus.cpha = pha; bus.mosi_data = d;
            if (k == restart_k) begin
                bus.start = 1'b1; bus.mosi_data = 8'hFF; bus.dvsr = 16'd0;
                bus.cpol = ~pol; bus.cpha = ~pha;
            end
            if (b2b && k == done1) begin
                bus.start = 1'b1; bus.mosi_data = 8'h3C;
            end
            if (b2b && done1 >= 0 && k == done1 + 1) begin
                bus.start = 1'b1; bus.mosi_data = d2;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int d1, d2, nd, nf, ff, fl;
        logic [7:0] ms;
        bit rl;
        logic ra;

        reset_n = 1'b0;
        bus.dvsr = '0; bus.cpol = 1'b1; bus.cpha = 1'b0; bus.start = 1'b0; bus.mosi_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_spi_clk", 32'(bus.spi_clk), 32'd0);
        check("rst_done", 32'(bus.done_tick), 32'd0);
        check("rst_miso_data", 32'(bus.miso_data), 32'h00);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_spi_clk_cpol", 32'(bus.spi_clk), 32'd1);

        // Mode 0, dvsr=0
        idle_cycle(1'b0, 1'b0);
        check("m0_idle_clk", 32'(bus.spi_clk), 32'd0);
        xfer(16'd0, 1'b0, 1'b0, 8'hA5, -1, 1'b0, 8'h00, 21, d1, d2, nd, ms, nf, ff, fl, rl, ra);
        check("m0_done_cycle", 32'(d1), 32'd16);
        check("m0_done_count", 32'(nd), 32'd1);
        check("m0_mosi_seq", 32'(ms), 32'(wire_seq(8'hA5)));
        check("m0_falls", 32'(nf), 32'd8);
        check("m0_fall_first", 32'(ff), 32'd3);
        check("m0_fall_last", 32'(fl), 32'd17);
        check("m0_ready_low", 32'(rl), 32'd1);
        check("m0_ready_after", 32'(ra), 32'd1);
        check("m0_miso_data", 32'(bus.miso_data), 32'hA5);

        // Mode 3, dvsr=3
        idle_cycle(1'b1, 1'b1);
        check("m3_idle_clk", 32'(bus.spi_clk), 32'd1);
        xfer(16'd3, 1'b1, 1'b1, 8'h3C, -1, 1'b0, 8'h00, 72, d1, d2, nd, ms, nf, ff, fl, rl, ra);
        check("m3_done_cycle", 32'(d1), 32'd68);
        check("m3_done_count", 32'(nd), 32'd1);
        check("m3_mosi_seq", 32'(ms), 32'(wire_seq(8'h3C)));
        check("m3_falls", 32'(nf), 32'd8);
        check("m3_fall_first", 32'(ff), 32'd5);
        check("m3_fall_last", 32'(fl), 32'd61);
        check("m3_end_clk", 32'(bus.spi_clk), 32'd1);
        check("m3_miso_data", 32'(bus.miso_data), 32'h3C);

        // start re-asserted mid-transfer with altered inputs
        idle_cycle(1'b0, 1'b0);
        xfer(16'd1, 1'b0, 1'b0, 8'h96, 6, 1'b0, 8'h00, 36, d1, d2, nd, ms, nf, ff, fl, rl, ra);
        check("rs_done_cycle", 32'(d1), 32'd32);
        check("rs_done_count", 32'(nd), 32'd1);
        check("rs_mosi_seq", 32'(ms), 32'(wire_seq(8'h96)));
        check("rs_ready_low", 32'(rl), 32'd1);
        check("rs_miso_data", 32'(bus.miso_data), 32'h96);

        // Back-to-back: start with done_tick ignored, start on next cycle accepted
        xfer(16'd0, 1'b0, 1'b0, 8'h5A, -1, 1'b1, 8'hC3, 40, d1, d2, nd, ms, nf, ff, fl, rl, ra);
        check("bb_done1", 32'(d1), 32'd16);
        check("bb_done2", 32'(d2), 32'd33);
        check("bb_done_count", 32'(nd), 32'd2);
        check("bb_ready_after", 32'(ra), 32'd1);
        check("bb_mosi_seq", 32'(ms), 32'(wire_seq(8'h5A)));
        check("bb_miso_data", 32'(bus.miso_data), 32'hC3);

        // Single set bit shows bit order
        xfer(16'd0, 1'b0, 1'b0, 8'h01, -1, 1'b0, 8'h00, 20, d1, d2, nd, ms, nf, ff, fl, rl, ra);
`ifdef SPI_XFER_LSB_FIRST_EN
        check("b1_mosi_seq", 32'(ms), 32'h80);
`else
        check("b1_mosi_seq", 32'(ms), 32'h01);
`endif
        check("b1_miso_data", 32'(bus.miso_data), 32'h01);

        // Reset mid-transfer (cpol=1 so the forced spi_clk=0 is visible)
        idle_cycle(1'b1, 1'b0);
        bus.dvsr = 16'd0; bus.mosi_data = 8'hE7; bus.start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("mr_ready", 32'(bus.ready), 32'd1);
        check("mr_spi_clk", 32'(bus.spi_clk), 32'd0);
        check("mr_done", 32'(bus.done_tick), 32'd0);
        check("mr_miso_data", 32'(bus.miso_data), 32'h00);
        reset_n = 1'b1;
        @(negedge clk);
        check("mr_rel_clk", 32'(bus.spi_clk), 32'd1);
        nd = 0; rl = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done_tick) nd++;
            if (!bus.ready) rl = 1'b0;
        end
        check("mr_no_done", 32'(nd), 32'd0);
        check("mr_ready_hold", 32'(rl), 32'd1);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule

// File: doc/spi_xfer_engine.md
SPI_XFER_ENGINE -- requirements
Module: spi_xfer_engine

Interface
REQ-001 Parameter: DVSR_BITS, 16, width of the half-period divisor input.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 dvsr  input  DVSR_BITS  half-period of spi_clk is dvsr+1 clk cycles.
REQ-005 cpol  input  1  clock polarity; idle level of spi_clk.
REQ-006 cpha  input  1  clock phase; 1 = data sampled on second edge.
REQ-007 start  input  1  single-cycle request to begin an 8-bit transfer.
REQ-008 mosi_data  input  8  byte to transmit.
REQ-009 miso  input  1  serial data from slave.
REQ-010 miso_data  output  8  byte received in the last completed transfer.
REQ-011 ready  output  1  high when idle and able to accept start.
REQ-012 done_tick  output  1  one-cycle pulse marking transfer completion.
REQ-013 spi_clk  output  1  registered serial clock.
REQ-014 mosi  output  1  serial data to slave.

Function
REQ-015 FSM states SHALL be IDLE, CPHA_DELAY, P0, P1; ready = (state == IDLE).
REQ-016 In IDLE, start=1 SHALL load mosi_data into the TX shift register, latch dvsr/cpol/cpha, clear the half-period counter and bit counter, then go to CPHA_DELAY if cpha=1, else P0.
REQ-017 start SHALL be ignored in any state other than IDLE; latched dvsr/cpol/cpha SHALL be unaffected by input changes mid-transfer.
REQ-018 CPHA_DELAY, P0 and P1 SHALL each last exactly dvsr+1 cycles, counted by the half-period counter; dvsr=0 gives one-cycle halves.
REQ-019 CPHA_DELAY exit SHALL go to P0.
REQ-020 At the last cycle of P0, miso SHALL be shifted into the RX shift register; next state P1.
REQ-021 At the last cycle of P1 with bit counter < 7: TX register shifts by one, bit counter increments, next state P0.
REQ-022 At the last cycle of P1 with bit counter = 7: done_tick = 1 for that cycle only, next state IDLE.
REQ-023 done_tick SHALL occur 16*(dvsr+1) + cpha*(dvsr+1) cycles after the accepting start cycle; ready rises the following cycle.
REQ-024 Internal phase clock p = (next state is P1 and cpha=0) or (next state is P0 and cpha=1); spi_clk register SHALL load p XOR cpol each cycle, using live cpol in IDLE and latched cpol otherwise.
REQ-025 mosi SHALL be driven combinationally from the outgoing end of the TX shift register.
REQ-026 miso_data SHALL equal the RX shift register, hold its value after done_tick, and only change while a transfer is active.
REQ-027 start asserted in the same cycle as done_tick SHALL be ignored; start on the next cycle (ready=1) SHALL be accepted.

Reset
REQ-028 reset_n=0 at any clock edge, including mid-transfer, SHALL force state IDLE, spi_clk=0, all counters 0, TX/RX registers 0, done_tick=0.
REQ-029 No done_tick SHALL be produced for a transfer aborted by reset.
REQ-030 One cycle after reset release, spi_clk SHALL equal cpol.

Configuration
REQ-031 Macro SPI_XFER_LSB_FIRST_EN defined: mosi = TX[0], TX shifts right, miso enters RX[7] shifting right (LSB first).
REQ-032 Macro undefined: mosi = TX[7], TX shifts left, miso enters RX[0] shifting left (MSB first).

Structure
REQ-033 Package spi_pkg SHALL hold the state enum type and the constant SPI_DATA_BITS = 8.
REQ-034 The block SHALL be a single module with no sub-modules; counters and shift registers are inline.

Verification
REQ-035 dvsr=0, cpol=0, cpha=0, start at cycle 0 with mosi_data=0xA5, slave loopback -> done_tick at cycle 16, mosi sequence 1,0,1,0,0,1,0,1, miso_data=0xA5.
REQ-036 dvsr=3, cpha=1, cpol=1 -> done_tick at cycle 68, spi_clk idles 1, 8 falling edges with 4-cycle half-periods, miso_data correct.
REQ-037 start re-asserted mid-transfer with mosi_data=0xFF -> ignored; original byte completes; ready low throughout.
REQ-038 reset_n=0 at cycle 5 of a transfer -> IDLE next cycle, spi_clk=0, no done_tick, ready=1 after release.
REQ-039 With SPI_XFER_LSB_FIRST_EN, 0x01 sent -> mosi first bit 1, then seven 0s; looped-back miso_data=0x01.
REQ-040 Back-to-back: start on the first ready cycle after done_tick -> second transfer accepted; both done_ticks one cycle wide.
